nibble_serializador: RTL and testbench

Upstream feeder for the bit-serial magnitude comparator in the NibbleMayor path. It accepts a pair of WIDTH-bit operands through a valid/ready handshake. It then presents them MSB-first, one bit pair per clock, on the comparator's bit inputs, with framing strobes. It supports back-to-back words with no idle bubble, so the comparator sees a continuous bit stream.

---
 rtl/nibble_serializador.sv | 68 ++++++
 tb/tb_nibble_serializador.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serializador.sv
// rtl/nibble_serializador.sv - MSB-first bit-pair serializer feeding the bit-serial magnitude comparator
module nibble_serializador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ns_valid,
    output logic             ns_ready,
    input  logic [WIDTH-1:0] ns_a,
    input  logic [WIDTH-1:0] ns_b,
    output logic             ns_bit_a,
    output logic             ns_bit_b,
    output logic             ns_bit_valid,
    output logic             ns_first,
    output logic             ns_last,
    output logic             ns_busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] TOP_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             in_shift;
    logic             at_last;
    logic             take;

    assign in_shift = (state == SHIFT);
    assign at_last  = in_shift && (count == '0);
    // Accepting on the last bit lets a new word follow with no idle bubble.
    assign ns_ready = (state == IDLE) || at_last;
    assign take     = ns_valid && ns_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            sa    <= '0;
            sb    <= '0;
        end else if (take) begin
            state <= SHIFT;
            count <= TOP_IDX;
            sa    <= ns_a;
            sb    <= ns_b;
        end else if (in_shift) begin
            sa <= sa << 1;
            sb <= sb << 1;
            if (count == '0) begin
                state <= IDLE;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign ns_bit_a     = in_shift && sa[WIDTH-1];
    assign ns_bit_b     = in_shift && sb[WIDTH-1];
    assign ns_bit_valid = in_shift;
    assign ns_busy      = in_shift;
    assign ns_first     = in_shift && (count == TOP_IDX);
    assign ns_last      = at_last;

endmodule

// File: tb/tb_nibble_serializador.sv
// tb/tb_nibble_serializador.sv - randomized scoreboard bench for nibble_serializador
module tb_nibble_serializador;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ns_valid = 1'b0;
    logic             ns_ready;
    logic [WIDTH-1:0] ns_a = '0;
    logic [WIDTH-1:0] ns_b = '0;
    logic             ns_bit_a;
    logic             ns_bit_b;
    logic             ns_bit_valid;
    logic             ns_first;
    logic             ns_last;
    logic             ns_busy;

    nibble_serializador #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ns_valid     (ns_valid),
        .ns_ready     (ns_ready),
        .ns_a         (ns_a),
        .ns_b         (ns_b),
        .ns_bit_a     (ns_bit_a),
        .ns_bit_b     (ns_bit_b),
        .ns_bit_valid (ns_bit_valid),
        .ns_first     (ns_first),
        .ns_last      (ns_last),
        .ns_busy      (ns_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     a;
        logic     b;
        logic     first;
        logic     last;
        int       cmp;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   dec = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: word bits listed MSB-first; comparator verdict 1 = A, 2 = B, 0 = equal.
    task automatic push_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        for (int i = 0; i < WIDTH; i++) begin
            e.a     = a[WIDTH-1-i];
            e.b     = b[WIDTH-1-i];
            e.first = (i == 0);
            e.last  = (i == WIDTH - 1);
            e.cmp   = (a > b) ? 1 : ((a < b) ? 2 : 0);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: pops one expected bit per live output cycle and runs a behavioural comparator.
    always @(negedge clk) begin
        if (!reset) begin
            if (ns_bit_valid) begin
                check("busy_live", ns_busy, 1);
                check("ready_rule", ns_ready, ns_last);
                check("first_last_excl", ns_first && ns_last, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("bit_a", ns_bit_a, e.a);
                    check("bit_b", ns_bit_b, e.b);
                    check("first", ns_first, e.first);
                    check("last", ns_last, e.last);
                    if (ns_first) dec = 0;
                    if (dec == 0 && ns_bit_a != ns_bit_b) dec = ns_bit_a ? 1 : 2;
                    if (ns_last) check("comparator", dec, e.cmp);
                end
            end else begin
                check("idle_outputs", {ns_bit_a, ns_bit_b, ns_first, ns_last, ns_busy}, 0);
                check("idle_ready", ns_ready, 1);
            end
        end
    end

    // Drives a word and returns the cycle count of its transfer edge (-1 on timeout).
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int acc);
        int n;
        n = 0;
        ns_valid = 1'b1;
        ns_a = a;
        ns_b = b;
        while (!ns_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!ns_ready) begin
            check("accept_timeout", 0, 1);
            acc = -1;
            ns_valid = 1'b0;
            return;
        end
        push_word(a, b);
        acc = cyc;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        ns_valid = 1'b0;
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int t0, t1, gap;
        logic [WIDTH-1:0] ra, rb;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("reset_outputs", {ns_bit_a, ns_bit_b, ns_bit_valid, ns_first, ns_last, ns_busy}, 0);
            check("reset_ready", ns_ready, 1);
            @(negedge clk); #1;
        end

        send(4'b1010, 4'b0110, t0);
        idle(WIDTH + 2);

        send(4'hF, 4'h0, t0);
        send(4'h3, 4'hC, t1);
        check("back_to_back_gap", t1 - t0, WIDTH);
        idle(WIDTH + 2);

        send(4'h1, 4'h2, t0);
        ns_valid = 1'b1;
        ns_a = 4'h9;
        ns_b = 4'h9;
        check("backpressure_ready", ns_ready, 0);
        send(4'h9, 4'h9, t1);
        check("backpressure_accept", t1 - t0, WIDTH);
        idle(WIDTH + 2);

        send(4'hA, 4'h3, t0);
        ns_valid = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk); #1;
        check("midreset_outputs", {ns_bit_a, ns_bit_b, ns_bit_valid, ns_first, ns_last, ns_busy}, 0);
        reset = 1'b0;
        check("midreset_ready", ns_ready, 1);
        send(4'h5, 4'h4, t0);
        idle(WIDTH + 2);

        send(4'h9, 4'h6, t0);
        send(4'h4, 4'h4, t0);
        send(4'h2, 4'hB, t0);
        idle(WIDTH + 2);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = (($urandom % 4) == 0) ? ra : WIDTH'($urandom);
            send(ra, rb, t0);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap + ($urandom_range(0, 1) * WIDTH));
        end
        idle(WIDTH + 3);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
